// File: rtl/uart_tx_fifo_if.sv
// Purpose: groups the byte-push side and the serial/status outputs of the UART transmitter.
// Latency: none, wires only.
// Backpressure: full is the only flow control; producers must hold off while it is high.
interface uart_tx_fifo_if #(
    parameter int PTR_W = 3
);
    logic             wr_en;
    logic [7:0]       wr_data;
    logic             full;
    logic [PTR_W:0]   count;
    logic             tx_busy;
    logic             dout;

    // Producer side: pushes bytes and watches the status and line.
    modport master (
        output wr_en,
        output wr_data,
        input  full,
        input  count,
        input  tx_busy,
        input  dout
    );

    // Transmitter side.
    modport slave (
        input  wr_en,
        input  wr_data,
        output full,
        output count,
        output tx_busy,
        output dout
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Purpose: 8N1 UART transmitter fed by a byte FIFO; drains the FIFO back-to-back onto dout.
// Latency: a push into an empty FIFO with the line idle drives the start bit on the next edge.
// Backpressure: full when FIFO_DEPTH bytes are queued; pushes while full are dropped silently.
module uart_tx_fifo #(
    parameter int BAUD_DIV   = 5208,
    parameter int FIFO_DEPTH = 8,
    parameter int PTR_W      = 3
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_fifo_if.slave     bus
);
    localparam int BCNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BCNT_W-1:0] BCNT_MAX   = BCNT_W'(BAUD_DIV - 1);
    localparam logic [PTR_W:0]    COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [2:0]        bitcnt_q, bitcnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              dout_q, dout_d;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              full_q, full_d;

    logic [7:0]        fifo_mem [FIFO_DEPTH];

    logic              push;
    logic              pop;
    logic              bit_end;

    // A push is judged against the registered full flag, so a pop on the
    // same edge never rescues a byte offered while full.
    assign push    = bus.wr_en && !full_q;
    assign bit_end = (bcnt_q == BCNT_MAX);

    // Frame sequencer: next state, baud/bit counters, shifter and line level.
    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        dout_d   = dout_q;
        pop      = 1'b0;

        case (state_q)
            IDLE: begin
                dout_d = 1'b1;
                bcnt_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem[rd_ptr_q];
                    dout_d  = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bcnt_d   = '0;
                    bitcnt_d = '0;
                    dout_d   = shift_q[0];
                    state_d  = DATA;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    bcnt_d   = '0;
                    shift_d  = {1'b0, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == 3'd7) begin
                        dout_d  = 1'b1;
                        state_d = STOP;
                    end else begin
                        dout_d = shift_q[1];
                    end
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    bcnt_d = '0;
                    // Chain straight into the next start bit when more is queued.
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = fifo_mem[rd_ptr_q];
                        dout_d  = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            default: begin
                dout_d  = 1'b1;
                bcnt_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // FIFO bookkeeping: pointers wrap naturally at PTR_W bits.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d = (count_d == COUNT_FULL);
    end

    // Control and status registers; reset aborts any frame and empties the FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            bcnt_q   <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            dout_q   <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcnt_q   <= bcnt_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            dout_q   <= dout_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    // Byte storage needs no reset: an empty count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.full    = full_q;
    assign bus.count   = count_q;
    assign bus.tx_busy = (state_q != IDLE);
    assign bus.dout    = dout_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
    localparam int BAUD_DIV   = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int PTR_W      = 3;
    localparam int FRAME      = 10 * BAUD_DIV;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    uart_tx_fifo_if #(.PTR_W(PTR_W)) bus ();

    uart_tx_fifo #(
        .BAUD_DIV   (BAUD_DIV),
        .FIFO_DEPTH (FIFO_DEPTH),
        .PTR_W      (PTR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check dout cycle by cycle for one frame of data d; the current cycle is
    // frame cycle 'skip' (0 = first cycle of the start bit). Returns at cycle 0
    // of whatever follows the frame.
    task automatic expect_frame(input logic [7:0] d, input int skip, input string tag);
        logic e;
        int   b;
        for (int i = skip; i < FRAME; i++) begin
            b = i / BAUD_DIV;
            if (b == 0)      e = 1'b0;
            else if (b == 9) e = 1'b1;
            else             e = d[b-1];
            chk($sformatf("%s byte%02h bit%0d cyc%0d", tag, d, b, i), {31'd0, bus.dout}, {31'd0, e});
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       saw_low;
        logic       saw_busy;
        logic [7:0] d;
        n_chk = 0;
        n_err = 0;
        reset       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;

        // T1: reset
        repeat (3) @(posedge clk);
        #1;
        chk("t1 rst dout",  {31'd0, bus.dout},    32'd1);
        chk("t1 rst count", {28'd0, bus.count},   32'd0);
        chk("t1 rst full",  {31'd0, bus.full},    32'd0);
        chk("t1 rst busy",  {31'd0, bus.tx_busy}, 32'd0);
        reset = 1'b1;
        tick();
        chk("t1 dout",  {31'd0, bus.dout},    32'd1);
        chk("t1 count", {28'd0, bus.count},   32'd0);
        chk("t1 full",  {31'd0, bus.full},    32'd0);
        chk("t1 busy",  {31'd0, bus.tx_busy}, 32'd0);

        // T2: single byte, wr_data changes after the push edge
        bus.wr_en = 1'b1; bus.wr_data = 8'h55;
        tick();
        bus.wr_en = 1'b0; bus.wr_data = 8'h00;
        chk("t2 count E0", {28'd0, bus.count},   32'd1);
        chk("t2 dout E0",  {31'd0, bus.dout},    32'd1);
        chk("t2 busy E0",  {31'd0, bus.tx_busy}, 32'd0);
        tick();
        chk("t2 count E1", {28'd0, bus.count},   32'd0);
        chk("t2 busy E1",  {31'd0, bus.tx_busy}, 32'd1);
        expect_frame(8'h55, 0, "t2");
        chk("t2 busy end", {31'd0, bus.tx_busy}, 32'd0);
        chk("t2 dout end", {31'd0, bus.dout},    32'd1);

        // T3: two bytes back to back
        repeat (3) tick();
        bus.wr_en = 1'b1; bus.wr_data = 8'hA3;
        tick();
        bus.wr_data = 8'h0F;
        tick();
        bus.wr_en = 1'b0;
        chk("t3 count E1", {28'd0, bus.count}, 32'd1);
        expect_frame(8'hA3, 0, "t3");
        expect_frame(8'h0F, 0, "t3");
        chk("t3 busy end", {31'd0, bus.tx_busy}, 32'd0);
        chk("t3 dout end", {31'd0, bus.dout},    32'd1);

        // T4: overflow, 10 pushes of 0x01..0x0A
        repeat (3) tick();
        for (int k = 1; k <= 10; k++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(k);
            tick();
            if (k == 8) begin
                chk("t4 count k8", {28'd0, bus.count}, 32'd7);
                chk("t4 full k8",  {31'd0, bus.full},  32'd0);
            end
            if (k == 9) begin
                chk("t4 count k9", {28'd0, bus.count}, 32'd8);
                chk("t4 full k9",  {31'd0, bus.full},  32'd1);
            end
        end
        bus.wr_en = 1'b0;
        chk("t4 count k10", {28'd0, bus.count}, 32'd8);
        chk("t4 full k10",  {31'd0, bus.full},  32'd1);
        // Frame 0x01 began on the second push edge, eight cycles ago.
        expect_frame(8'h01, 8, "t4");
        chk("t4 full after pop", {31'd0, bus.full}, 32'd0);
        for (int k = 2; k <= 9; k++) begin
            d = 8'(k);
            expect_frame(d, 0, "t4");
        end
        saw_low = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (bus.dout == 1'b0) saw_low = 1'b1;
            tick();
        end
        chk("t4 idle after 0x09", {31'd0, saw_low},   32'd0);
        chk("t4 count drained",   {28'd0, bus.count}, 32'd0);

        // T5: three rounds of five bytes, pointers wrap past FIFO_DEPTH
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 5; k++) begin
                bus.wr_en = 1'b1; bus.wr_data = 8'(8'h10 * (r + 1) + k);
                tick();
            end
            bus.wr_en = 1'b0;
            chk($sformatf("t5 r%0d count", r), {28'd0, bus.count}, 32'd4);
            d = 8'(8'h10 * (r + 1));
            expect_frame(d, 3, "t5");
            for (int k = 1; k < 5; k++) begin
                d = 8'(8'h10 * (r + 1) + k);
                expect_frame(d, 0, "t5");
            end
            chk($sformatf("t5 r%0d busy end", r), {31'd0, bus.tx_busy}, 32'd0);
            tick();
        end

        // T6: reset during data bit 3 with a second byte queued
        bus.wr_en = 1'b1; bus.wr_data = 8'hFF;
        tick();
        bus.wr_data = 8'h12;
        tick();
        bus.wr_en = 1'b0;
        repeat (17) tick();
        chk("t6 busy pre",  {31'd0, bus.tx_busy}, 32'd1);
        chk("t6 count pre", {28'd0, bus.count},   32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6 dout rst",  {31'd0, bus.dout},    32'd1);
        chk("t6 count rst", {28'd0, bus.count},   32'd0);
        chk("t6 busy rst",  {31'd0, bus.tx_busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        saw_low  = 1'b0;
        saw_busy = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (bus.dout == 1'b0) saw_low  = 1'b1;
            if (bus.tx_busy)      saw_busy = 1'b1;
        end
        chk("t6 quiet dout",  {31'd0, saw_low},   32'd0);
        chk("t6 quiet busy",  {31'd0, saw_busy},  32'd0);
        chk("t6 quiet count", {28'd0, bus.count}, 32'd0);
        bus.wr_en = 1'b1; bus.wr_data = 8'h3C;
        tick();
        bus.wr_en = 1'b0;
        chk("t6 dout E0", {31'd0, bus.dout}, 32'd1);
        tick();
        expect_frame(8'h3C, 0, "t6");
        chk("t6 busy end", {31'd0, bus.tx_busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
